// File: rtl/mtm_riscv_btn_conditioner.sv
// Push-button conditioner: per-channel 2-flop synchroniser, stability-counter debounce,
// and registered level plus one-cycle press / release / long-hold event pulses.
module mtm_riscv_btn_conditioner #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_hold
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_CYCLES - 1);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic          sync1_q, sync2_q;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          level_q, level_d;
    logic          sat_q, sat_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          hold_q, hold_d;
    logic          flip_c;

    // Debounce: level follows sync2 only after DEBOUNCE_CYCLES consecutive differing edges.
    always_comb begin
      dcnt_d  = dcnt_q;
      level_d = level_q;
      flip_c  = 1'b0;
      if (sync2_q == level_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == DCNT_LAST) begin
        level_d = sync2_q;
        dcnt_d  = '0;
        flip_c  = 1'b1;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end

    // Event pulses; a flip in either direction restarts the hold count, so a release
    // landing on the final hold edge suppresses the pulse.
    always_comb begin
      hcnt_d    = hcnt_q;
      sat_d     = sat_q;
      hold_d    = 1'b0;
      press_d   = flip_c & sync2_q;
      release_d = flip_c & ~sync2_q;
      if (flip_c || !level_q) begin
        hcnt_d = '0;
        sat_d  = 1'b0;
      end else if (!sat_q) begin
        hcnt_d = hcnt_q + HW'(1);
        hold_d = (hcnt_q == HCNT_LAST);
        sat_d  = (hcnt_q == HCNT_LAST);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        dcnt_q    <= '0;
        hcnt_q    <= '0;
        level_q   <= 1'b0;
        sat_q     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        hold_q    <= 1'b0;
      end else begin
        sync1_q   <= btn_in[g];
        sync2_q   <= sync1_q;
        dcnt_q    <= dcnt_d;
        hcnt_q    <= hcnt_d;
        level_q   <= level_d;
        sat_q     <= sat_d;
        press_q   <= press_d;
        release_q <= release_d;
        hold_q    <= hold_d;
      end
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
    assign btn_hold[g]    = hold_q;
  end

endmodule

// File: tb/tb_mtm_riscv_btn_conditioner.sv
// Directed bench for the button conditioner: a window-based model checked every cycle,
// plus literal timing pins for each scenario. Instance a: D=4,H=10; instance b: D=1,H=1.
module tb_mtm_riscv_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_a = 4'h0, btn_b = 4'h0;
  logic [3:0] lvl_a, prs_a, rel_a, hld_a;
  logic [3:0] lvl_b, prs_b, rel_b, hld_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mtm_riscv_btn_conditioner #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_a),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_hold(hld_a)
  );

  mtm_riscv_btn_conditioner #(.CHANNELS(4), .DEBOUNCE_CYCLES(1), .HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_b),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .btn_hold(hld_b)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: hist[i][k] is btn_in seen k edges ago; the synchronised value used at an edge is
  // the sample two edges older. The level flips once the last D synchronised values all
  // differ from it; hold fires H edges after the rise if the level is still high.
  logic [3:0] hist [2][8];
  logic [3:0] m_lvl [2];
  logic [3:0] m_prs [2];
  logic [3:0] m_rel [2];
  logic [3:0] m_hld [2];
  int         rise  [2][4];
  int         ecnt;

  function automatic int dcyc(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int hcyc(input int i);
    return (i == 0) ? 10 : 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt = 0;
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 8; k++) hist[i][k] = 4'h0;
        m_lvl[i] = 4'h0; m_prs[i] = 4'h0; m_rel[i] = 4'h0; m_hld[i] = 4'h0;
        for (int c = 0; c < 4; c++) rise[i][c] = 0;
      end
    end else begin
      ecnt = ecnt + 1;
      for (int i = 0; i < 2; i++) begin
        for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = (i == 0) ? btn_a : btn_b;
        for (int c = 0; c < 4; c++) begin
          bit all_diff;
          all_diff = 1'b1;
          for (int k = 0; k < dcyc(i); k++)
            if (hist[i][2+k][c] == m_lvl[i][c]) all_diff = 1'b0;
          m_prs[i][c] = 1'b0;
          m_rel[i][c] = 1'b0;
          if (all_diff) begin
            m_lvl[i][c] = ~m_lvl[i][c];
            if (m_lvl[i][c]) begin
              m_prs[i][c] = 1'b1;
              rise[i][c]  = ecnt;
            end else begin
              m_rel[i][c] = 1'b1;
            end
          end
          m_hld[i][c] = m_lvl[i][c] && ((ecnt - rise[i][c]) == hcyc(i));
        end
      end
    end
  end

  always @(negedge clk) begin
    check("a_level",   lvl_a, m_lvl[0]);
    check("a_press",   prs_a, m_prs[0]);
    check("a_release", rel_a, m_rel[0]);
    check("a_hold",    hld_a, m_hld[0]);
    check("b_level",   lvl_b, m_lvl[1]);
    check("b_press",   prs_b, m_prs[1]);
    check("b_release", rel_b, m_rel[1]);
    check("b_hold",    hld_b, m_hld[1]);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset, then reset asserted mid-cycle while all buttons are held.
    tick(3);
    check("rst_level", lvl_a, 4'h0);
    rst_n = 1'b1;
    btn_a = 4'hF;
    tick(6);
    check("pre_rst_level", lvl_a, 4'hF);
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check("async_level",   lvl_a, 4'h0);
    check("async_press",   prs_a, 4'h0);
    check("async_release", rel_a, 4'h0);
    check("async_hold",    hld_a, 4'h0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check("s1_level_e5", lvl_a, 4'h0);
    tick(1);
    check("s1_level_e6", lvl_a, 4'hF);
    check("s1_press_e6", prs_a, 4'hF);
    check("s1_rel_e6",   rel_a, 4'h0);
    tick(1);
    check("s1_press_e7", prs_a, 4'h0);
    tick(15);
    btn_a = 4'h0;
    tick(6);
    check("s1_release", rel_a, 4'hF);
    tick(10);

    // Clean press on ch0.
    btn_a = 4'b0001;
    tick(5);
    check("s2_level_e5", lvl_a, 4'b0000);
    tick(1);
    check("s2_level_e6", lvl_a, 4'b0001);
    check("s2_press_e6", prs_a, 4'b0001);
    tick(1);
    check("s2_press_e7", prs_a, 4'b0000);
    tick(9);
    check("s2_hold_e16", hld_a, 4'b0001);
    tick(1);
    check("s2_hold_e17", hld_a, 4'b0000);
    tick(3);
    btn_a = 4'b0000;
    tick(5);
    check("s2_level_rel5", lvl_a, 4'b0001);
    tick(1);
    check("s2_release", rel_a, 4'b0001);
    check("s2_level_rel6", lvl_a, 4'b0000);
    tick(1);
    check("s2_release_end", rel_a, 4'b0000);
    tick(5);

    // Bouncing ch1, then settle high.
    for (int r = 0; r < 4; r++) begin
      btn_a[1] = (r % 2 == 0);
      tick(3);
    end
    tick(2);
    check("s3_bounce_level", lvl_a, 4'b0000);
    btn_a[1] = 1'b1;
    tick(5);
    check("s3_press_e5", prs_a, 4'b0000);
    tick(1);
    check("s3_press_e6", prs_a, 4'b0010);
    check("s3_level_e6", lvl_a, 4'b0010);
    tick(3);
    btn_a = 4'h0;
    tick(20);

    // Short press on ch2: no hold, then a fresh press times its hold from the new rise.
    btn_a = 4'b0100;
    tick(6);
    check("s4_press", prs_a, 4'b0100);
    tick(2);
    btn_a = 4'b0000;
    tick(6);
    check("s4_release", rel_a, 4'b0100);
    check("s4_nohold",  hld_a, 4'b0000);
    tick(2);
    btn_a = 4'b0100;
    tick(6);
    check("s4_repress", prs_a, 4'b0100);
    tick(9);
    check("s4_hold_early", hld_a, 4'b0000);
    tick(1);
    check("s4_hold", hld_a, 4'b0100);
    btn_a = 4'b0000;
    tick(20);

    // Independent channels.
    btn_a = 4'b1001;
    tick(2);
    btn_a = 4'b1011;
    tick(4);
    check("s5_press_a", prs_a, 4'b1001);
    tick(2);
    check("s5_press_b", prs_a, 4'b0010);
    check("s5_level",   lvl_a, 4'b1011);
    btn_a = 4'b0000;
    tick(20);

    // Minimum debounce and hold on instance b.
    btn_b = 4'b0001;
    tick(2);
    check("s6_level_e2", lvl_b, 4'b0000);
    tick(1);
    check("s6_level_e3", lvl_b, 4'b0001);
    check("s6_press_e3", prs_b, 4'b0001);
    check("s6_hold_e3",  hld_b, 4'b0000);
    tick(1);
    check("s6_hold_e4",  hld_b, 4'b0001);
    check("s6_press_e4", prs_b, 4'b0000);
    tick(1);
    check("s6_hold_e5",  hld_b, 4'b0000);
    btn_b = 4'b0000;
    tick(3);
    check("s6_release", rel_b, 4'b0001);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
